// File: rtl/usb_phy_pkg.sv
// rtl/usb_phy_pkg.sv - shared USB PHY line states, error codes and rx framing states
package usb_phy_pkg;

  // Raw {dp,dm} line states; J/K meaning depends on the latched speed mode
  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] SE1  = 2'b11;
  localparam logic [1:0] FS_J = 2'b10;
  localparam logic [1:0] LS_J = 2'b01;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_EOP_SHORT = 3'd1,
    ERR_EOP_LONG  = 3'd2,
    ERR_EOP_K     = 3'd3,
    ERR_SE1       = 3'd4,
    ERR_BABBLE    = 3'd5
  } err_code_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_EOP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Idle (J) line state for the given speed mode: 0 = full speed, 1 = low speed
  function automatic logic [1:0] j_state(input logic ls);
    return ls ? LS_J : FS_J;
  endfunction

endpackage

// File: rtl/usb_eop_checker.sv
// rtl/usb_eop_checker.sv - SE0 run counter and end-of-packet line classification
module usb_eop_checker
  import usb_phy_pkg::*;
#(
  parameter int EOP_SE0_MIN = 2,
  parameter int EOP_SE0_MAX = 3
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start_i,
  input  logic      eval_i,
  input  logic [1:0] line_i,
  input  logic      ls_i,
  output logic      eop_ok_o,
  output logic      eop_err_o,
  err_code_e        err_code_o
);

  // Wide enough to hold the saturation value plus one increment without wrapping
  localparam int SE0_W = $clog2(EOP_SE0_MAX + 3);

  logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d, se0_inc;

  assign se0_inc = se0_cnt_q + SE0_W'(1);

  // SE0 run length: first SE0 is seen by the FSM in DATA, later ones here; saturates at MAX+1
  always_comb begin
    se0_cnt_d = se0_cnt_q;
    if (start_i) begin
      se0_cnt_d = SE0_W'(1);
    end else if (eval_i && (line_i == SE0)) begin
      se0_cnt_d = (se0_inc > SE0_W'(EOP_SE0_MAX + 1)) ? SE0_W'(EOP_SE0_MAX + 1) : se0_inc;
    end
  end

  // SE0 run counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) se0_cnt_q <= '0;
    else       se0_cnt_q <= se0_cnt_d;
  end

  // Classify the current strobed line state; SE1 wins over every EOP rule
  always_comb begin
    eop_ok_o   = 1'b0;
    eop_err_o  = 1'b0;
    err_code_o = ERR_NONE;
    if (eval_i) begin
      case (line_i)
        SE1: begin
          eop_err_o  = 1'b1;
          err_code_o = ERR_SE1;
        end
        SE0: begin
          if (se0_inc > SE0_W'(EOP_SE0_MAX)) begin
            eop_err_o  = 1'b1;
            err_code_o = ERR_EOP_LONG;
          end
        end
        default: begin
          if (line_i == j_state(ls_i)) begin
            if (se0_cnt_q >= SE0_W'(EOP_SE0_MIN)) begin
              eop_ok_o = 1'b1;
            end else begin
              eop_err_o  = 1'b1;
              err_code_o = ERR_EOP_SHORT;
            end
          end else begin
            eop_err_o  = 1'b1;
            err_code_o = ERR_EOP_K;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// rtl/usb_rx_packet_ctrl.sv - receive packet framing FSM: data window, bit count, EOP validation
module usb_rx_packet_ctrl
  import usb_phy_pkg::*;
#(
  parameter int  EOP_SE0_MIN = 2,
  parameter int  EOP_SE0_MAX = 3,
  parameter int  MAX_BITS    = 8256,
  localparam int CNT_W       = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       usb_line_state,
  input  logic             ls_mode,
  input  logic             bit_strobe,
  input  logic             sync_detected,
  output logic             data_enable,
  output logic             in_packet,
  output logic             packet_done,
  output logic             error,
  output logic [2:0]       error_code,
  output logic [CNT_W-1:0] pkt_bits
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] pkt_bits_q, pkt_bits_d;
  err_code_e        err_code_q, err_code_d;
  logic             ls_q, ls_d;

  logic      eop_start, eop_eval, eop_ok, eop_err;
  err_code_e eop_code;

  assign eop_start = (state_q == ST_DATA) && bit_strobe && (usb_line_state == SE0);
  assign eop_eval  = (state_q == ST_EOP) && bit_strobe;

  usb_eop_checker #(
    .EOP_SE0_MIN (EOP_SE0_MIN),
    .EOP_SE0_MAX (EOP_SE0_MAX)
  ) u_eop_checker (
    .clk        (clk),
    .reset      (reset),
    .start_i    (eop_start),
    .eval_i     (eop_eval),
    .line_i     (usb_line_state),
    .ls_i       (ls_q),
    .eop_ok_o   (eop_ok),
    .eop_err_o  (eop_err),
    .err_code_o (eop_code)
  );

  // Framing FSM; pkt_bits and error_code are loaded on entry to DONE/ERROR so they align with the pulse
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pkt_bits_d = pkt_bits_q;
    err_code_d = err_code_q;
    ls_d       = ls_q;
    case (state_q)
      ST_IDLE: begin
        ls_d = ls_mode;
        if (sync_detected) begin
          state_d    = ST_DATA;
          bit_cnt_d  = '0;
          err_code_d = ERR_NONE;
        end
      end
      ST_DATA: begin
        if (bit_strobe) begin
          case (usb_line_state)
            SE1: begin
              state_d    = ST_ERROR;
              err_code_d = ERR_SE1;
              pkt_bits_d = bit_cnt_q;
            end
            SE0: state_d = ST_EOP;
            default: begin
              if (bit_cnt_q == CNT_W'(MAX_BITS)) begin
                state_d    = ST_ERROR;
                err_code_d = ERR_BABBLE;
                pkt_bits_d = bit_cnt_q;
              end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
              end
            end
          endcase
        end
      end
      ST_EOP: begin
        if (eop_err) begin
          state_d    = ST_ERROR;
          err_code_d = eop_code;
          pkt_bits_d = bit_cnt_q;
        end else if (eop_ok) begin
          state_d    = ST_DONE;
          pkt_bits_d = bit_cnt_q;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      pkt_bits_q <= '0;
      err_code_q <= ERR_NONE;
      ls_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pkt_bits_q <= pkt_bits_d;
      err_code_q <= err_code_d;
      ls_q       <= ls_d;
    end
  end

  assign data_enable = (state_q == ST_DATA);
  assign in_packet   = (state_q == ST_DATA) || (state_q == ST_EOP);
  assign packet_done = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERROR);
  assign error_code  = err_code_q;
  assign pkt_bits    = pkt_bits_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// tb/tb_usb_rx_packet_ctrl.sv - randomized self-checking bench for usb_rx_packet_ctrl
module tb_usb_rx_packet_ctrl;

  localparam int MAXB    = 32;
  localparam int SE0_MIN = 2;
  localparam int SE0_MAX = 3;
  localparam int CW      = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    usb_line_state;
  logic          ls_mode;
  logic          bit_strobe;
  logic          sync_detected;
  logic          data_enable;
  logic          in_packet;
  logic          packet_done;
  logic          error;
  logic [2:0]    error_code;
  logic [CW-1:0] pkt_bits;

  always #5 clk = ~clk;

  usb_rx_packet_ctrl #(
    .EOP_SE0_MIN (SE0_MIN),
    .EOP_SE0_MAX (SE0_MAX),
    .MAX_BITS    (MAXB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .usb_line_state (usb_line_state),
    .ls_mode        (ls_mode),
    .bit_strobe     (bit_strobe),
    .sync_detected  (sync_detected),
    .data_enable    (data_enable),
    .in_packet      (in_packet),
    .packet_done    (packet_done),
    .error          (error),
    .error_code     (error_code),
    .pkt_bits       (pkt_bits)
  );

  int checks = 0;
  int errors = 0;

  int            done_cnt  = 0;
  int            err_cnt   = 0;
  int            de_cycles = 0;
  logic [2:0]    last_code = '0;
  logic [CW-1:0] last_bits = '0;

  logic [1:0] syms[$];
  bit         ls_cur = 1'b0;

  // Pulse and data-window observer, sampled away from the active edge
  always @(negedge clk) begin
    if (packet_done) done_cnt++;
    if (error) err_cnt++;
    if (packet_done || error) begin
      last_code = error_code;
      last_bits = pkt_bits;
    end
    if (data_enable) de_cycles++;
  end

  function automatic logic [1:0] j_of(input bit ls);
    return ls ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] k_of(input bit ls);
    return ls ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] rand_jk();
    return ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
  endfunction

  // Reference: outcome of a packet from its strobed symbol list, by the framing rules
  task automatic model_packet(output int kind, output int code, output int bits,
                              output int len, output int de_syms);
    int n = 0;
    int r = 0;
    logic [1:0] t;
    while (n < syms.size() && (syms[n] == 2'b10 || syms[n] == 2'b01)) n++;
    if (n > MAXB) begin
      kind = 1; code = 5; bits = MAXB; len = MAXB + 1; de_syms = MAXB + 1;
      return;
    end
    bits = n;
    de_syms = n + 1;
    if (syms[n] == 2'b11) begin
      kind = 1; code = 4; len = n + 1;
      return;
    end
    while (n + r < syms.size() && syms[n + r] == 2'b00) r++;
    if (r > SE0_MAX) begin
      kind = 1; code = 2; len = n + SE0_MAX + 1;
      return;
    end
    t = syms[n + r];
    len = n + r + 1;
    if (t == 2'b11) begin
      kind = 1; code = 4;
    end else if (t == j_of(ls_cur)) begin
      if (r >= SE0_MIN) begin kind = 0; code = 0; end
      else begin kind = 1; code = 1; end
    end else begin
      kind = 1; code = 3;
    end
  endtask

  task automatic run_packet(input int period, input string name);
    int kind, code, bits, len, de_syms;
    int d0, e0, de0, w;
    model_packet(kind, code, bits, len, de_syms);
    d0 = done_cnt;
    e0 = err_cnt;
    ls_mode        = ls_cur;
    sync_detected  = 1'b1;
    bit_strobe     = 1'($urandom_range(0, 1));
    usb_line_state = j_of(ls_cur);
    @(posedge clk); #1;
    de0 = de_cycles;
    sync_detected = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < period; c++) begin
        ls_mode = 1'($urandom_range(0, 1));
        if (c < period - 1) begin
          bit_strobe     = 1'b0;
          usb_line_state = 2'($urandom_range(0, 3));
        end else begin
          bit_strobe     = 1'b1;
          usb_line_state = syms[i];
        end
        @(negedge clk);
        if (i == 0 && c == 0) begin
          checks++;
          if (data_enable !== 1'b1 || error_code !== 3'd0) begin
            errors++;
            $display("FAIL %s entry: data_enable=%b error_code=%0d, required 1 and 0", name, data_enable, error_code);
          end
        end else if (c < period - 1) begin
          checks++;
          if (in_packet !== 1'b1 || packet_done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s hold sym%0d: in_packet=%b done=%b error=%b, required 1 0 0", name, i, in_packet, packet_done, error);
          end
        end
        @(posedge clk); #1;
      end
    end
    bit_strobe     = 1'b0;
    usb_line_state = j_of(ls_cur);
    ls_mode        = ls_cur;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 6) begin
      @(negedge clk); #1;
      w++;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt == d0 && err_cnt == e0) begin
      errors++;
      $display("FAIL %s timeout: no done/error pulse within 6 cycles", name);
    end
    checks++;
    if ((done_cnt - d0) != (kind == 0 ? 1 : 0) || (err_cnt - e0) != (kind == 1 ? 1 : 0)) begin
      errors++;
      $display("FAIL %s pulses: done_cycles=%0d error_cycles=%0d, required %0d %0d", name,
               done_cnt - d0, err_cnt - e0, kind == 0 ? 1 : 0, kind == 1 ? 1 : 0);
    end
    checks++;
    if (last_code !== 3'(code) || last_bits !== CW'(bits)) begin
      errors++;
      $display("FAIL %s result: code=%0d bits=%0d, required %0d %0d", name, last_code, last_bits, code, bits);
    end
    checks++;
    if ((de_cycles - de0) != de_syms * period) begin
      errors++;
      $display("FAIL %s data_window: %0d cycles, required %0d", name, de_cycles - de0, de_syms * period);
    end
    checks++;
    if (error_code !== 3'(code) || pkt_bits !== CW'(bits) || in_packet !== 1'b0) begin
      errors++;
      $display("FAIL %s held: code=%0d bits=%0d in_packet=%b, required %0d %0d 0", name, error_code, pkt_bits, in_packet, code, bits);
    end
  endtask

  task automatic push_bits(input int n);
    for (int i = 0; i < n; i++) syms.push_back(rand_jk());
  endtask

  task automatic test_reset();
    reset = 1'b1; usb_line_state = 2'b10; ls_mode = 1'b0; bit_strobe = 1'b0; sync_detected = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({data_enable, in_packet, packet_done, error} !== 4'b0 || error_code !== 3'd0 || pkt_bits !== '0) begin
      errors++;
      $display("FAIL reset: de=%b ip=%b done=%b err=%b code=%0d bits=%0d, required all 0",
               data_enable, in_packet, packet_done, error, error_code, pkt_bits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fs_basic();
    ls_cur = 1'b0;
    syms.delete(); push_bits(16);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(1, "fs_basic");
  endtask

  task automatic test_ls_mode();
    ls_cur = 1'b1;
    syms.delete(); push_bits(8);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(1, "ls_eop_k");
    syms.delete(); push_bits(8);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b01);
    run_packet(1, "ls_clean");
    ls_cur = 1'b0;
  endtask

  task automatic test_eop_timing();
    syms.delete(); push_bits(7);
    syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(1, "eop_short");
    syms.delete(); push_bits(7);
    repeat (4) syms.push_back(2'b00);
    run_packet(1, "eop_long");
    syms.delete(); push_bits(5);
    repeat (3) syms.push_back(2'b00);
    syms.push_back(2'b10);
    run_packet(2, "eop_max_ok");
  endtask

  task automatic test_strobe_div();
    syms.delete(); push_bits(8);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(4, "strobe_div4");
  endtask

  task automatic test_babble_se1();
    syms.delete(); push_bits(33);
    run_packet(1, "babble");
    syms.delete(); push_bits(32);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(1, "max_bits_ok");
    syms.delete(); push_bits(5);
    syms.push_back(2'b11);
    run_packet(1, "se1_data");
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    ls_cur = 1'b0;
    ls_mode = 1'b0; sync_detected = 1'b1; bit_strobe = 1'b1; usb_line_state = 2'b10;
    @(posedge clk); #1;
    sync_detected = 1'b0;
    for (int i = 0; i < 5; i++) begin
      usb_line_state = rand_jk();
      @(posedge clk); #1;
    end
    usb_line_state = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (in_packet !== 1'b1 || data_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid in_eop: in_packet=%b data_enable=%b, required 1 0", in_packet, data_enable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({data_enable, in_packet, packet_done, error} !== 4'b0 || error_code !== 3'd0 || pkt_bits !== '0) begin
      errors++;
      $display("FAIL reset_mid async: de=%b ip=%b done=%b err=%b code=%0d bits=%0d, required all 0",
               data_enable, in_packet, packet_done, error, error_code, pkt_bits);
    end
    @(posedge clk); #1;
    reset = 1'b0; bit_strobe = 1'b0; usb_line_state = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++;
      $display("FAIL reset_mid pulses: done=%0d error=%0d, required 0 0", done_cnt - d0, err_cnt - e0);
    end
    syms.delete(); push_bits(3);
    syms.push_back(2'b00); syms.push_back(2'b00); syms.push_back(2'b10);
    run_packet(1, "after_reset");
  endtask

  task automatic test_random();
    int nb, r, t;
    for (int p = 0; p < 24; p++) begin
      ls_cur = 1'($urandom_range(0, 1));
      syms.delete();
      nb = $urandom_range(0, 36);
      push_bits(nb);
      if ($urandom_range(0, 5) == 0) begin
        syms.push_back(2'b11);
      end else begin
        r = $urandom_range(1, 5);
        repeat (r) syms.push_back(2'b00);
        t = $urandom_range(0, 3);
        if (t <= 1)      syms.push_back(j_of(ls_cur));
        else if (t == 2) syms.push_back(k_of(ls_cur));
        else             syms.push_back(2'b11);
      end
      run_packet($urandom_range(1, 3), $sformatf("random%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_fs_basic();
    test_ls_mode();
    test_eop_timing();
    test_strobe_div();
    test_babble_se1();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_ctrl.md
Name: usb_rx_packet_ctrl

Overview:
Parametrised receive-side packet framing controller for the USB PHY. It sits between the SYNC detector and the NRZI/bit-unstuff datapath. It opens the data window after SYNC, counts packet bits, and validates EOP (SE0 length, terminating J) for full- or low-speed lines. Each packet ends with a one-cycle done or error pulse, plus a classified error code and the received bit count.

Parameters:
EOP_SE0_MIN, 2, minimum SE0 bit-times accepted as EOP
EOP_SE0_MAX, 3, maximum SE0 bit-times; longer is an error
MAX_BITS, 8256, maximum data bit-times before babble error
CNT_W, $clog2(MAX_BITS+1), bit counter width (localparam, derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
usb_line_state  in  2  {dp,dm}: 00 SE0, 11 SE1, 10/01 J or K by mode
ls_mode  in  1  0 = full speed (J=10), 1 = low speed (J=01); sampled in IDLE only
bit_strobe  in  1  one-cycle bit-time sample strobe; tie 1 for per-clock sampling
sync_detected  in  1  pulse from SYNC FSM
data_enable  out  1  high in DATA state
in_packet  out  1  high in DATA or EOP state
packet_done  out  1  one-cycle pulse, valid packet end
error  out  1  one-cycle pulse, framing error
error_code  out  3  0 none, 1 EOP_SHORT, 2 EOP_LONG, 3 EOP_K, 4 SE1, 5 BABBLE
pkt_bits  out  CNT_W  data bit-times received in last packet

Behaviour:
- All state is on clk, async reset. Reset sets state IDLE, all outputs 0, counters 0, latched mode 0 (FS).
- All outputs are decoded from registers; there is no combinational path from input to output.
- States: IDLE, DATA, EOP, DONE, ERROR.
- IDLE
  - Latch ls_mode every cycle.
  - sync_detected=1 → DATA next cycle (one-cycle latency; independent of bit_strobe).
  - On that transition, clear the bit counter and error_code.
- DATA
  - data_enable=1. Line is evaluated only when bit_strobe=1.
  - 10/01: bit counter +1. If the counter already equals MAX_BITS → ERROR, code BABBLE.
  - 00: → EOP, se0_cnt=1.
  - 11: → ERROR, code SE1.
  - sync_detected is ignored.
- EOP (evaluated on bit_strobe only)
  - SE0: se0_cnt+1. If the result exceeds EOP_SE0_MAX → ERROR, code EOP_LONG.
  - J (per latched mode) with se0_cnt>=EOP_SE0_MIN → DONE.
  - J with se0_cnt<EOP_SE0_MIN → ERROR, code EOP_SHORT.
  - K → ERROR, code EOP_K.
  - 11 → ERROR, code SE1.
  - se0_cnt is held at EOP_SE0_MAX+1 saturation.
- DONE: packet_done=1 for exactly one cycle; pkt_bits updated from the counter; → IDLE unconditionally.
- ERROR: error=1 for exactly one cycle; pkt_bits updated; → IDLE. error_code is held until the next DATA entry or reset.
- sync_detected in DONE/ERROR is dropped; the upstream SYNC FSM cannot re-fire within one cycle.
- Priority in the same strobe: SE1 check first, then the babble/EOP checks.
- Reset mid-packet: immediate return to IDLE; no done or error pulse is issued.
- pkt_bits holds its value between packets and never wraps: the counter stops at MAX_BITS because babble fires first.
- When bit_strobe=0 in DATA/EOP, state and counters are held.

Decomposition:
- Shared package usb_phy_pkg holds:
  - Line-state constants: SE0=2'b00, SE1=2'b11, FS_J=2'b10, LS_J=2'b01.
  - Error-code enum (3 bits).
  - State encoding.
- One natural sub-module: usb_eop_checker. It owns se0_cnt and J/K/SE1 classification and returns eop_ok/eop_err/err_code to the main FSM.

Test Plan:
- FS, strobe=1: sync pulse, 16 J/K cycles, 2×SE0, J → data_enable high 16+ cycles; packet_done one cycle; pkt_bits=16; error_code=0.
- LS mode (ls_mode=1): sync, 8 bits, 2×SE0, then 10 (K for LS) → error pulse, error_code=3; then 01 ends the next packet cleanly.
- EOP timing: 1×SE0 then J → error_code=1. Separately, 4×SE0 → error_code=2 on the 4th SE0 strobe.
- bit_strobe every 4th clock: 8 bits + EOP → pkt_bits=8; state unchanged on non-strobe cycles; SE0 on a non-strobe cycle is ignored.
- MAX_BITS=32 override: 33 non-SE0 strobes → error_code=5, pkt_bits=32. SE1 mid-data → error_code=4.
- Assert reset during EOP → IDLE next edge, no pulses. Next sync then starts cleanly with counters at 0.
